// File: rtl/mc_pkg.sv
// Shared types and helpers for the motion-compensation residual engine.
// Coordinate clamping implements edge replication of the reference frame.
package mc_pkg;

    localparam int MC_PIXEL_WIDTH = 8;

    typedef logic signed [MC_PIXEL_WIDTH:0] residual_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mc_state_e;

    function automatic int mc_clamp(input int v, input int hi);
        if (v < 0) begin
            return 0;
        end else if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/mc_res_fifo.sv
// Two-entry valid/ready FIFO carrying a residual and its last-of-block tag.
// Supports simultaneous push and pop; the head entry is stable while not popped.
module mc_res_fifo #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic [1:0]   count
);

    logic [W:0] mem_q [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push, pop;

    always_comb begin
        push     = in_valid;
        pop      = out_valid & out_ready;
        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ push;
        count_d  = count_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_last, in_data};
        end
    end

    assign out_valid            = (count_q != 2'd0);
    assign {out_last, out_data} = mem_q[rd_ptr_q];
    assign count                = count_q;

endmodule

// File: rtl/mc_residual_engine.sv
// Streams one MB_SIZE x MB_SIZE block: fetches motion-compensated reference pixels,
// emits signed residuals (cur - ref) through a 2-entry FIFO and accumulates the block SAD.
module mc_residual_engine
    import mc_pkg::*;
#(
    parameter int MB_SIZE     = 4,
    parameter int PIXEL_WIDTH = 8,
    parameter int FRAME_W     = 8,
    parameter int FRAME_H     = 8,
    parameter int MV_WIDTH    = 6
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic [$clog2(FRAME_W)-1:0]                 mb_x,
    input  logic [$clog2(FRAME_H)-1:0]                 mb_y,
    input  logic signed [MV_WIDTH-1:0]                 mv_x,
    input  logic signed [MV_WIDTH-1:0]                 mv_y,
    output logic                                       busy,
    output logic                                       done,
    output logic [PIXEL_WIDTH+2*$clog2(MB_SIZE):0]     sad_out,
    output logic                                       ref_rd_en,
    output logic [$clog2(FRAME_W*FRAME_H)-1:0]         ref_rd_addr,
    input  logic [PIXEL_WIDTH-1:0]                     ref_rd_data,
    input  logic                                       cur_valid,
    output logic                                       cur_ready,
    input  logic [PIXEL_WIDTH-1:0]                     cur_data,
    output logic                                       res_valid,
    input  logic                                       res_ready,
    output logic signed [PIXEL_WIDTH:0]                res_data,
    output logic                                       res_last
);

    localparam int NPIX = MB_SIZE * MB_SIZE;
    localparam int LW   = $clog2(MB_SIZE);
    localparam int KW   = $clog2(NPIX) + 1;
    localparam int XW   = $clog2(FRAME_W);
    localparam int YW   = $clog2(FRAME_H);
    localparam int AW   = $clog2(FRAME_W * FRAME_H);
    localparam int SW   = PIXEL_WIDTH + 1 + 2 * LW;

    mc_state_e                   state_q, state_d;
    logic [XW-1:0]               mb_x_q, mb_x_d;
    logic [YW-1:0]               mb_y_q, mb_y_d;
    logic signed [MV_WIDTH-1:0]  mv_x_q, mv_x_d, mv_y_q, mv_y_d;
    logic [KW-1:0]               k_q, k_d;
    logic                        inflight_q, inflight_d;
    logic [PIXEL_WIDTH-1:0]      cur1_q, cur1_d;
    logic                        last1_q, last1_d;
    logic [SW-1:0]               sad_q, sad_d, sad_out_q, sad_out_d;
    logic                        done_q, done_d;

    logic [LW-1:0]               pix_i, pix_j;
    int                          fetch_x, fetch_y;
    logic                        accept, pop;
    logic signed [PIXEL_WIDTH:0] res_w;
    logic [PIXEL_WIDTH:0]        res_abs;
    logic                        fifo_valid, fifo_last;
    logic [PIXEL_WIDTH:0]        fifo_data;
    logic [1:0]                  fifo_count;

    always_comb begin
        state_d    = state_q;
        mb_x_d     = mb_x_q;
        mb_y_d     = mb_y_q;
        mv_x_d     = mv_x_q;
        mv_y_d     = mv_y_q;
        k_d        = k_q;
        inflight_d = 1'b0;
        cur1_d     = cur1_q;
        last1_d    = last1_q;
        sad_d      = sad_q;
        sad_out_d  = sad_out_q;
        done_d     = 1'b0;

        pop   = fifo_valid & res_ready;
        pix_j = k_q[LW-1:0];
        pix_i = k_q[2*LW-1:LW];

        fetch_x     = mc_clamp(int'(mb_x_q) + int'(pix_j) + int'(mv_x_q), FRAME_W - 1);
        fetch_y     = mc_clamp(int'(mb_y_q) + int'(pix_i) + int'(mv_y_q), FRAME_H - 1);
        ref_rd_addr = AW'(fetch_y * FRAME_W + fetch_x);

        // A slot freed by this cycle's pop counts as free, so a drained consumer
        // sustains one pixel per cycle while the FIFO still never overfills.
        cur_ready = (state_q == RUN) && (k_q < KW'(NPIX)) &&
                    ((int'(fifo_count) + int'(inflight_q) - int'(pop)) < 2);
        accept    = cur_valid & cur_ready;
        ref_rd_en = accept;

        res_w   = $signed({1'b0, cur1_q}) - $signed({1'b0, ref_rd_data});
        res_abs = res_w[PIXEL_WIDTH] ? $unsigned(-res_w) : $unsigned(res_w);
        if (inflight_q) begin
            sad_d = sad_q + SW'(res_abs);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    mb_x_d  = mb_x;
                    mb_y_d  = mb_y;
                    mv_x_d  = mv_x;
                    mv_y_d  = mv_y;
                    k_d     = '0;
                    sad_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    k_d        = k_q + KW'(1);
                    inflight_d = 1'b1;
                    cur1_d     = cur_data;
                    last1_d    = (k_q == KW'(NPIX - 1));
                end
                if (pop && fifo_last) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    sad_out_d = sad_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mb_x_q     <= '0;
            mb_y_q     <= '0;
            mv_x_q     <= '0;
            mv_y_q     <= '0;
            k_q        <= '0;
            inflight_q <= 1'b0;
            cur1_q     <= '0;
            last1_q    <= 1'b0;
            sad_q      <= '0;
            sad_out_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mb_x_q     <= mb_x_d;
            mb_y_q     <= mb_y_d;
            mv_x_q     <= mv_x_d;
            mv_y_q     <= mv_y_d;
            k_q        <= k_d;
            inflight_q <= inflight_d;
            cur1_q     <= cur1_d;
            last1_q    <= last1_d;
            sad_q      <= sad_d;
            sad_out_q  <= sad_out_d;
            done_q     <= done_d;
        end
    end

    mc_res_fifo #(.W(PIXEL_WIDTH + 1)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inflight_q),
        .in_data   (res_w),
        .in_last   (last1_q),
        .out_valid (fifo_valid),
        .out_ready (res_ready),
        .out_data  (fifo_data),
        .out_last  (fifo_last),
        .count     (fifo_count)
    );

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign sad_out   = sad_out_q;
    assign res_valid = fifo_valid;
    assign res_data  = fifo_data;
    assign res_last  = fifo_last;

endmodule

// File: tb/tb_mc_residual_engine.sv
// Directed bench for mc_residual_engine on an 8x8 reference frame where ref[r][c] = 8r+c.
// Expected residuals and SADs are hand-derived per scenario.
module tb_mc_residual_engine;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [2:0]         mb_x, mb_y;
    logic signed [5:0]  mv_x, mv_y;
    logic               busy, done;
    logic [12:0]        sad_out;
    logic               ref_rd_en;
    logic [5:0]         ref_rd_addr;
    logic [7:0]         ref_rd_data;
    logic               cur_valid, cur_ready;
    logic [7:0]         cur_data;
    logic               res_valid, res_ready;
    logic signed [8:0]  res_data;
    logic               res_last;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q [16];
    int got_res [$];

    mc_residual_engine dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mb_x        (mb_x),
        .mb_y        (mb_y),
        .mv_x        (mv_x),
        .mv_y        (mv_y),
        .busy        (busy),
        .done        (done),
        .sad_out     (sad_out),
        .ref_rd_en   (ref_rd_en),
        .ref_rd_addr (ref_rd_addr),
        .ref_rd_data (ref_rd_data),
        .cur_valid   (cur_valid),
        .cur_ready   (cur_ready),
        .cur_data    (cur_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_last    (res_last)
    );

    always #5 clk = ~clk;

    // Reference memory: address row*8+col holds 8*row+col, one cycle read latency.
    always @(posedge clk) begin
        if (ref_rd_en) ref_rd_data <= {2'b00, ref_rd_addr};
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_block(input string name, input int mbx, input int mby, input int mvx,
                             input int mvy, input int cval, input int rmode, input int abort_n,
                             input int interloper, input int exp_sad);
        int nacc = 0;
        int done_cnt = 0;
        int stall_cnt = 0;
        int rd_viol = 0;
        int last_idx = -1;
        int sad_seen = -1;
        int busy_bad = 0;
        got_res.delete();
        cur_data  = 8'(cval);
        cur_valid = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        mb_x  = 3'(mbx);
        mb_y  = 3'(mby);
        mv_x  = 6'(mvx);
        mv_y  = 6'(mvy);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_after_start"}, busy, 1);
        for (int cyc = 0; cyc < 400 && done_cnt == 0; cyc++) begin
            res_ready = (rmode == 0) || (cyc % 3 == 0);
            cur_valid = (nacc < 16);
            start     = (interloper != 0) && (cyc == 3);
            if (start) begin
                mv_x = -6'sd2;
                mv_y = -6'sd2;
            end
            #1;
            if (cur_valid && cur_ready) nacc++;
            else if (cur_valid) stall_cnt++;
            if (ref_rd_en !== (cur_valid && cur_ready)) rd_viol++;
            if (res_valid && res_ready) begin
                got_res.push_back(int'(res_data));
                if (res_last) last_idx = got_res.size() - 1;
            end
            if (done) begin
                done_cnt++;
                sad_seen = int'(sad_out);
                if (busy) busy_bad = 1;
            end
            if (abort_n > 0 && got_res.size() == abort_n) begin
                reset     = 1'b1;
                start     = 1'b0;
                cur_valid = 1'b0;
                res_ready = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                #1;
                check({name, "_res_valid_after_reset"}, res_valid, 0);
                check({name, "_busy_after_reset"}, busy, 0);
                check({name, "_cur_ready_after_reset"}, cur_ready, 0);
                repeat (8) begin
                    @(negedge clk);
                    #1;
                    if (done) done_cnt++;
                end
                check({name, "_no_done"}, done_cnt, 0);
                $display("%s: aborted after %0d residuals", name, abort_n);
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "_done_count"}, done_cnt, 1);
        check({name, "_num_res"}, got_res.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < got_res.size()) check($sformatf("%s_res%0d", name, i), got_res[i], exp_q[i]);
        end
        check({name, "_last_idx"}, last_idx, 15);
        check({name, "_sad_at_done"}, sad_seen, exp_sad);
        check({name, "_busy_with_done"}, busy_bad, 0);
        check({name, "_rd_en_gating"}, rd_viol, 0);
        if (rmode != 0) check({name, "_backpressure_stall"}, int'(stall_cnt > 0), 1);
        #1;
        check({name, "_done_pulse_width"}, done, 0);
        check({name, "_sad_held"}, sad_out, exp_sad);
        $display("%s: %0d residuals, sad=%0d, stalls=%0d", name, got_res.size(), sad_seen, stall_cnt);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mb_x = '0; mb_y = '0; mv_x = '0; mv_y = '0;
        cur_valid = 1'b0; cur_data = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sad", sad_out, 0);
        check("rst_rd_en", ref_rd_en, 0);
        check("rst_cur_ready", cur_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_last", res_last, 0);
        reset = 1'b0;

        // Refs 25+8i+j, so residual = 75-8i-j.
        for (int k = 0; k < 16; k++) exp_q[k] = 75 - 8 * (k / 4) - (k % 4);
        run_block("t1_basic", 0, 0, 1, 3, 100, 0, 0, 0, 984);

        for (int k = 0; k < 16; k++) exp_q[k] = 37;
        run_block("t2_clamp_hi", 4, 4, 3, 3, 100, 0, 0, 0, 592);

        exp_q = '{0, 0, 0, -1, 0, 0, 0, -1, 0, 0, 0, -1, -8, -8, -8, -9};
        run_block("t3_clamp_lo", 0, 0, -2, -2, 0, 0, 0, 0, 36);

        for (int k = 0; k < 16; k++) exp_q[k] = 75 - 8 * (k / 4) - (k % 4);
        run_block("t4_backpressure", 0, 0, 1, 3, 100, 1, 0, 0, 984);
        run_block("t5_abort", 0, 0, 1, 3, 100, 0, 5, 0, 984);
        run_block("t5_restart", 0, 0, 1, 3, 100, 0, 0, 0, 984);
        run_block("t6_start_busy", 0, 0, 1, 3, 100, 0, 0, 1, 984);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
